// File: rtl/extensor_imediato_pipe_if.sv
// Handshake bundle between the decode stage and the immediate extender.
// Ports: in_valid/in_ready/in_imm/in_modo (producer -> extender),
//        out_valid/out_ready/out_dado (extender -> ALU-B / branch-adder muxes).
interface extensor_imediato_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_modo;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_dado;

    // Environment side: drives immediates in, consumes results.
    modport master (
        output in_valid, in_imm, in_modo, out_ready,
        input  in_ready, out_valid, out_dado
    );

    // Extender side.
    modport slave (
        input  in_valid, in_imm, in_modo, out_ready,
        output in_ready, out_valid, out_dado
    );
endinterface

// File: rtl/extensor_imediato_pipe.sv
// Purpose : IN_W -> OUT_W immediate extender (sign / zero / upper / branch<<2), registered output.
// Latency : 1 cycle from input transfer to out_dado; 1 result/cycle with out_ready held high.
// Backpr. : 2-entry skid (head + skid); in_ready is registered, never combinational from out_ready.
// Ports   : clk, rst (sync, active-high), bus (extensor_imediato_pipe_if.slave);
//           out_contagem[15:0] (output-transfer counter) present only with EXTENSOR_CONTADOR_EN.
module extensor_imediato_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    extensor_imediato_pipe_if.slave        bus
`ifdef EXTENSOR_CONTADOR_EN
    ,
    output logic [15:0]                    out_contagem
`endif
);

    if (OUT_W < 2*IN_W) begin : g_param_check
        $error("extensor_imediato_pipe: OUT_W must be >= 2*IN_W");
    end

    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        UM    = 2'd1,
        CHEIO = 2'd2
    } ocup_t;

    ocup_t              estado_q;
    logic [OUT_W-1:0]   head_q;
    logic [OUT_W-1:0]   skid_q;
    logic               out_valid_q;
    logic               in_ready_q;
`ifdef EXTENSOR_CONTADOR_EN
    logic [15:0]        contagem_q;
`endif

    logic [OUT_W-1:0]   sext_w;
    logic [OUT_W-1:0]   ext_d;
    logic               in_fire;
    logic               out_fire;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    // Extended value of the immediate currently on the input bus.
    always_comb begin
        sext_w = OUT_W'($signed(bus.in_imm));
        ext_d  = sext_w;
        case (bus.in_modo)
            2'd1:    ext_d = OUT_W'(bus.in_imm);
            2'd2:    ext_d = OUT_W'(bus.in_imm) << IN_W;
            2'd3:    ext_d = sext_w << 2;   // top two sign bits fall off
            default: ext_d = sext_w;
        endcase
    end

    // Occupancy FSM; out_valid/in_ready are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= VAZIO;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (estado_q)
                VAZIO: begin
                    if (in_fire) begin
                        head_q      <= ext_d;
                        estado_q    <= UM;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                UM: begin
                    if (in_fire && out_fire) begin
                        // Head leaves and is replaced in the same edge.
                        head_q <= ext_d;
                    end else if (in_fire) begin
                        skid_q      <= ext_d;
                        estado_q    <= CHEIO;
                        in_ready_q  <= 1'b0;
                    end else if (out_fire) begin
                        estado_q    <= VAZIO;
                        out_valid_q <= 1'b0;
                    end
                end
                CHEIO: begin
                    if (out_fire) begin
                        head_q      <= skid_q;
                        estado_q    <= UM;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    estado_q    <= VAZIO;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef EXTENSOR_CONTADOR_EN
    // Free-running count of output transfers, wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            contagem_q <= 16'd0;
        end else if (out_fire) begin
            contagem_q <= contagem_q + 16'd1;
        end
    end

    assign out_contagem = contagem_q;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_dado  = head_q;

endmodule

// File: doc/extensor_imediato_pipe.md
Name: extensor_imediato_pipe

Overview:
- Parametrised successor to the datapath's combinational 16->32 sign extender.
- Extends an IN_W-bit immediate to OUT_W bits in one of four modes: sign, zero, upper/LUI, or branch offset (sign-extend then shift left 2).
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer.
- Sits between the decode stage and the ALU-B / branch-adder operand muxes of the pipelined MIPS core, so stalls in either stage are absorbed without combinational ready paths.

Parameters:
- IN_W, 16, immediate width in bits.
- OUT_W, 32, extended width in bits. Must satisfy OUT_W >= 2*IN_W; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  producer presents an immediate
- in_ready  output  1  block can accept an immediate this cycle
- in_imm  input  IN_W  immediate value
- in_modo  input  2  extension mode: 0=sign, 1=zero, 2=upper, 3=branch
- out_valid  output  1  out_dado holds a valid result
- out_ready  input  1  consumer accepts out_dado this cycle
- out_dado  output  OUT_W  extended result

Behaviour:
- Clocking and reset: one clock domain. All state updates on posedge clk.
- rst=1 at an edge, regardless of other inputs or mid-transfer state:
  - occupancy -> VAZIO
  - out_valid=0, in_ready=1, out_dado=0, both buffer entries cleared
  - Any in-flight data is discarded. A transfer offered in the same cycle as rst is dropped.
- Handshake:
  - Input transfer when in_valid && in_ready at an edge.
  - Output transfer when out_valid && out_ready at an edge.
  - in_ready depends only on registered state, never on out_ready.
- Extension, computed combinationally from in_imm/in_modo and captured at input transfer:
  - Mode 0 (sign): {(OUT_W-IN_W){in_imm[IN_W-1]}, in_imm}
  - Mode 1 (zero): {(OUT_W-IN_W){0}, in_imm}
  - Mode 2 (upper): {(OUT_W-2*IN_W){0}, in_imm, IN_W{0}}
  - Mode 3 (branch): sign-extend result << 2, truncated to OUT_W; the top two bits shifted out are lost.
- Occupancy FSM. The head register drives out_dado; the skid register holds the second entry.
  - VAZIO: out_valid=0, in_ready=1. On input transfer -> UM, result written to head.
  - UM: out_valid=1, in_ready=1.
    - Input only -> CHEIO, result to skid.
    - Output only -> VAZIO.
    - Both simultaneously -> stay UM, new result written to head.
  - CHEIO: out_valid=1, in_ready=0. On output transfer -> UM, skid moves to head.
- Latency: 1 cycle. A value accepted at edge N appears on out_dado after edge N when head is free.
- Throughput: 1 result/cycle with out_ready held high.
- Ordering: strict FIFO; no reordering or duplication.
- out_dado holds its last value when out_valid=0. Consumers must ignore it.
- in_imm/in_modo are don't-care when in_valid=0.

Optional Feature:
- Macro: EXTENSOR_CONTADOR_EN.
- Defined:
  - Adds port out_contagem, output, 16 bits.
  - Counts output transfers; +1 per transfer.
  - Wraps 0xFFFF -> 0x0000.
  - Cleared to 0 by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Mode vectors, out_ready=1. Each result must appear one cycle after acceptance:
  - in_imm=0x8000, modo=0 -> 0xFFFF8000
  - in_imm=0x8000, modo=1 -> 0x00008000
  - in_imm=0x1234, modo=2 -> 0x12340000
  - in_imm=0xFFFF, modo=3 -> 0xFFFFFFFC
- Streaming, out_ready=1:
  - Stimulus: 0x0001, 0x0002, 0x0003 in consecutive cycles, modo=0.
  - Response: out_dado 0x1, 0x2, 0x3 in consecutive cycles; in_ready never drops.
- Backpressure, out_ready=0:
  - Stimulus: send 0x00AA, then 0x00BB, modo=1.
  - Response: in_ready=0 after second accept, out_dado=0x000000AA held.
  - Then raise out_ready: 0xAA then 0xBB delivered in order; in_ready returns to 1 one cycle after first drain.
- Simultaneous accept and drain in UM:
  - Stimulus: in 0x7FFF modo=3 while current head drains.
  - Response: next out_dado=0x0001FFFC; state stays UM.
- Reset mid-operation:
  - Stimulus: CHEIO with out_ready=0, assert rst one cycle.
  - Response: next cycle out_valid=0, in_ready=1, out_dado=0. Buffered data never emitted.
- With EXTENSOR_CONTADOR_EN:
  - Stimulus: 65537 transfers.
  - Response: out_contagem=0x0001. After rst, out_contagem=0x0000.
